// File: rtl/ppu_scroll_pkg.sv
// Shared types and register-select codes for the PPU scroll/address controller.
// The loopy_addr_t field layout matches the v/t registers bit-for-bit.
package ppu_scroll_pkg;

    typedef struct packed {
        logic [2:0] fine_y;
        logic [1:0] nt;
        logic [4:0] coarse_y;
        logic [4:0] coarse_x;
    } loopy_addr_t;

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd2;
    localparam logic [2:0] REG_SCROLL = 3'd5;
    localparam logic [2:0] REG_ADDR   = 3'd6;
    localparam logic [2:0] REG_DATA   = 3'd7;

endpackage

// File: rtl/ppu_scroll_incr.sv
// Combinational coarse-X / Y increment of the current VRAM address v.
// Horizontal and vertical increments touch disjoint fields, so both may apply at once.
module ppu_scroll_incr
    import ppu_scroll_pkg::*;
#(
    parameter int COARSE_Y_LAST = 29
) (
    input  loopy_addr_t v,
    input  logic        inc_hori,
    input  logic        inc_vert,
    output loopy_addr_t v_next
);

    localparam logic [4:0] CY_LAST = 5'(COARSE_Y_LAST);

    always_comb begin
        v_next = v;
        if (inc_hori) begin
            if (v.coarse_x == 5'd31) begin
                v_next.coarse_x = 5'd0;
                v_next.nt[0]    = ~v.nt[0];
            end else begin
                v_next.coarse_x = v.coarse_x + 5'd1;
            end
        end
        if (inc_vert) begin
            if (v.fine_y != 3'd7) begin
                v_next.fine_y = v.fine_y + 3'd1;
            end else begin
                v_next.fine_y = 3'd0;
                // Rows past the last visible one (attribute area) wrap without a nametable flip
                if (v.coarse_y == CY_LAST) begin
                    v_next.coarse_y = 5'd0;
                    v_next.nt[1]    = ~v.nt[1];
                end else if (v.coarse_y == 5'd31) begin
                    v_next.coarse_y = 5'd0;
                end else begin
                    v_next.coarse_y = v.coarse_y + 5'd1;
                end
            end
        end
    end

endmodule

// File: rtl/ppu_scroll_ctrl.sv
// PPU scroll/address state (v, t, x, w): CPU register writes plus renderer increments/copies.
// Define PPU_SCROLL_RENDER_2007_GLITCH_EN to make a 0x2007 access during rendering bump X and Y.
module ppu_scroll_ctrl
    import ppu_scroll_pkg::*;
#(
    parameter int COARSE_Y_LAST = 29,
    parameter int VRAM_ADDR_W   = 14,
    parameter int INC_LARGE     = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   reg_write_en,
    input  logic                   reg_read_en,
    input  logic [2:0]             reg_sel,
    input  logic [7:0]             reg_data_in,
    input  logic                   inc_mode,
    input  logic                   render_en,
    input  logic                   inc_hori,
    input  logic                   inc_vert,
    input  logic                   copy_hori,
    input  logic                   copy_vert,
    output logic [VRAM_ADDR_W-1:0] vram_addr,
    output logic [2:0]             fine_x,
    output logic                   write_toggle,
    output logic [14:0]            tmp_addr
);

    localparam logic [14:0] INC_BIG = 15'(INC_LARGE);

    logic [14:0] v_reg, v_next;
    logic [14:0] t_reg, t_next;
    logic [2:0]  x_reg, x_next;
    logic        w_reg, w_next;
    logic        addr_commit;
    logic        data_access;
    logic        do_inc_hori, do_inc_vert;
    loopy_addr_t v_cur, v_inc;

    assign data_access = (reg_write_en || reg_read_en) && (reg_sel == REG_DATA);
    assign v_cur       = loopy_addr_t'(v_reg);

`ifdef PPU_SCROLL_RENDER_2007_GLITCH_EN
    assign do_inc_hori = render_en && (inc_hori || data_access);
    assign do_inc_vert = render_en && (inc_vert || data_access);
`else
    assign do_inc_hori = render_en && inc_hori;
    assign do_inc_vert = render_en && inc_vert;
`endif

    ppu_scroll_incr #(
        .COARSE_Y_LAST(COARSE_Y_LAST)
    ) u_incr (
        .v        (v_cur),
        .inc_hori (do_inc_hori),
        .inc_vert (do_inc_vert),
        .v_next   (v_inc)
    );

    // A simultaneous write wins over the status-read toggle clear
    always_comb begin
        t_next      = t_reg;
        x_next      = x_reg;
        w_next      = w_reg;
        addr_commit = 1'b0;
        if (reg_write_en) begin
            case (reg_sel)
                REG_CTRL: t_next[11:10] = reg_data_in[1:0];
                REG_SCROLL: begin
                    if (!w_reg) begin
                        t_next[4:0] = reg_data_in[7:3];
                        x_next      = reg_data_in[2:0];
                        w_next      = 1'b1;
                    end else begin
                        t_next[14:12] = reg_data_in[2:0];
                        t_next[9:5]   = reg_data_in[7:3];
                        w_next        = 1'b0;
                    end
                end
                REG_ADDR: begin
                    if (!w_reg) begin
                        t_next[13:8] = reg_data_in[5:0];
                        t_next[14]   = 1'b0;
                        w_next       = 1'b1;
                    end else begin
                        t_next[7:0] = reg_data_in;
                        w_next      = 1'b0;
                        addr_commit = 1'b1;
                    end
                end
                default: ;
            endcase
        end else if (reg_read_en && (reg_sel == REG_STATUS)) begin
            w_next = 1'b0;
        end
    end

    // Priority: second 0x2006 write > copies > renderer increments > linear 0x2007 step
    always_comb begin
        v_next = v_reg;
        if (addr_commit) begin
            v_next = t_next;
        end else if (render_en) begin
            v_next = v_inc;
            if (copy_hori) begin
                v_next[10]  = t_reg[10];
                v_next[4:0] = t_reg[4:0];
            end
            if (copy_vert) begin
                v_next[14:11] = t_reg[14:11];
                v_next[9:5]   = t_reg[9:5];
            end
        end else if (data_access) begin
            v_next = v_reg + (inc_mode ? INC_BIG : 15'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_reg <= '0;
            t_reg <= '0;
            x_reg <= '0;
            w_reg <= 1'b0;
        end else begin
            v_reg <= v_next;
            t_reg <= t_next;
            x_reg <= x_next;
            w_reg <= w_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < VRAM_ADDR_W; gi++) begin : g_vram_addr
            assign vram_addr[gi] = v_reg[gi];
        end
    endgenerate

    assign fine_x       = x_reg;
    assign write_toggle = w_reg;
    assign tmp_addr     = t_reg;

endmodule

// File: tb/tb_ppu_scroll_ctrl.sv
// Directed scoreboard bench for ppu_scroll_ctrl: stimulus pushes expected state, a monitor compares.
// Honours PPU_SCROLL_RENDER_2007_GLITCH_EN when computing the rendering 0x2007 expectation.
module tb_ppu_scroll_ctrl;

    typedef struct {
        string       name;
        logic [14:0] v;
        logic [14:0] t;
        logic [2:0]  x;
        logic        w;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        reg_write_en, reg_read_en;
    logic [2:0]  reg_sel;
    logic [7:0]  reg_data_in;
    logic        inc_mode, render_en;
    logic        inc_hori, inc_vert, copy_hori, copy_vert;
    logic [13:0] vram_addr;
    logic [2:0]  fine_x;
    logic        write_toggle;
    logic [14:0] tmp_addr;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [14:0] v_glitch;

    ppu_scroll_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .reg_write_en (reg_write_en),
        .reg_read_en  (reg_read_en),
        .reg_sel      (reg_sel),
        .reg_data_in  (reg_data_in),
        .inc_mode     (inc_mode),
        .render_en    (render_en),
        .inc_hori     (inc_hori),
        .inc_vert     (inc_vert),
        .copy_hori    (copy_hori),
        .copy_vert    (copy_vert),
        .vram_addr    (vram_addr),
        .fine_x       (fine_x),
        .write_toggle (write_toggle),
        .tmp_addr     (tmp_addr)
    );

    always #5 clk = ~clk;

    task automatic wr(input logic [2:0] sel, input logic [7:0] d);
        reg_write_en = 1'b1;
        reg_sel      = sel;
        reg_data_in  = d;
    endtask

    task automatic rd(input logic [2:0] sel);
        reg_read_en = 1'b1;
        reg_sel     = sel;
    endtask

    task automatic rstrobe(input logic ih, input logic iv, input logic ch, input logic cv);
        inc_hori  = ih;
        inc_vert  = iv;
        copy_hori = ch;
        copy_vert = cv;
    endtask

    // Commit the driven strobes on one edge, then queue the state expected afterwards
    task automatic step(input string name, input logic [14:0] ev, input logic [14:0] et,
                        input logic [2:0] ex, input logic ew);
        exp_t e;
        @(posedge clk);
        #1;
        rst          = 1'b0;
        reg_write_en = 1'b0;
        reg_read_en  = 1'b0;
        rstrobe(1'b0, 1'b0, 1'b0, 1'b0);
        e.name = name;
        e.v    = ev;
        e.t    = et;
        e.x    = ex;
        e.w    = ew;
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            n_cmp++;
            if (vram_addr !== mon_e.v[13:0] || tmp_addr !== mon_e.t ||
                fine_x !== mon_e.x || write_toggle !== mon_e.w) begin
                n_bad++;
                $display("FAIL %s: got v=%h t=%h x=%0d w=%0b, expected v=%h t=%h x=%0d w=%0b",
                         mon_e.name, vram_addr, tmp_addr, fine_x, write_toggle,
                         mon_e.v[13:0], mon_e.t, mon_e.x, mon_e.w);
            end else begin
                $display("ok   %s: v=%h t=%h x=%0d w=%0b", mon_e.name, vram_addr, tmp_addr,
                         fine_x, write_toggle);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
`ifdef PPU_SCROLL_RENDER_2007_GLITCH_EN
        v_glitch = 15'h2543;
`else
        v_glitch = 15'h1542;
`endif
        rst = 1'b1;
        reg_write_en = 1'b0;
        reg_read_en  = 1'b0;
        reg_sel      = 3'd0;
        reg_data_in  = 8'd0;
        inc_mode     = 1'b0;
        render_en    = 1'b0;
        rstrobe(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        step("reset",        15'h0000, 15'h0000, 3'd0, 1'b0);

        wr(5, 8'h7D);  step("scroll_1st",   15'h0000, 15'h000F, 3'd5, 1'b1);
        wr(5, 8'h5E);  step("scroll_2nd",   15'h0000, 15'h616F, 3'd5, 1'b0);
        wr(6, 8'h3D);  step("addr_1st",     15'h0000, 15'h3D6F, 3'd5, 1'b1);
        wr(6, 8'hF0);  step("addr_2nd",     15'h3DF0, 15'h3DF0, 3'd5, 1'b0);
        wr(6, 8'h12);  step("addr_midpair", 15'h3DF0, 15'h12F0, 3'd5, 1'b1);
        rd(2);         step("status_clr_w", 15'h3DF0, 15'h12F0, 3'd5, 1'b0);
        wr(5, 8'h00);  step("scroll_zero",  15'h3DF0, 15'h12E0, 3'd0, 1'b1);
        rd(3);         step("read_other",   15'h3DF0, 15'h12E0, 3'd0, 1'b1);
        rd(2);         step("status_clr2",  15'h3DF0, 15'h12E0, 3'd0, 1'b0);
        wr(6, 8'h20);  step("addr_hi_20",   15'h3DF0, 15'h20E0, 3'd0, 1'b1);
        wr(6, 8'h00);  step("addr_lo_00",   15'h2000, 15'h2000, 3'd0, 1'b0);
        wr(7, 8'h55);  step("data_inc1",    15'h2001, 15'h2000, 3'd0, 1'b0);

        wr(0, 8'h03);  step("ctrl_nt3",     15'h2001, 15'h2C00, 3'd0, 1'b0);
        wr(5, 8'h80);  step("scroll_cx16",  15'h2001, 15'h2C10, 3'd0, 1'b1);
        wr(5, 8'hFF);  step("scroll_fy7",   15'h2001, 15'h7FF0, 3'd0, 1'b0);
        render_en = 1'b1;
        rstrobe(1'b0, 1'b0, 1'b1, 1'b1);
        step("copy_both",    15'h7FF0, 15'h7FF0, 3'd0, 1'b0);
        render_en = 1'b0;
        inc_mode  = 1'b1;
        rd(7);         step("data_inc32_wrap", 15'h0010, 15'h7FF0, 3'd0, 1'b0);
        rstrobe(1'b1, 1'b1, 1'b1, 1'b1);
        step("render_off_ignored", 15'h0010, 15'h7FF0, 3'd0, 1'b0);

        wr(6, 8'h00);  step("addr_hi_00",   15'h0010, 15'h00F0, 3'd0, 1'b1);
        wr(6, 8'h1F);  step("addr_lo_1F",   15'h001F, 15'h001F, 3'd0, 1'b0);
        render_en = 1'b1;
        rstrobe(1'b1, 1'b0, 1'b0, 1'b0);
        step("inc_hori_wrap", 15'h0400, 15'h001F, 3'd0, 1'b0);

        wr(5, 8'h00);  step("scroll_clr",   15'h0400, 15'h0000, 3'd0, 1'b1);
        wr(5, 8'hEF);  step("scroll_cy29",  15'h0400, 15'h73A0, 3'd0, 1'b0);
        rstrobe(1'b0, 1'b0, 1'b1, 1'b1);
        step("copy_cy29",    15'h73A0, 15'h73A0, 3'd0, 1'b0);
        rstrobe(1'b0, 1'b1, 1'b0, 1'b0);
        step("inc_vert_cy29", 15'h0800, 15'h73A0, 3'd0, 1'b0);
        rstrobe(1'b0, 1'b1, 1'b0, 1'b0);
        step("inc_vert_fy",  15'h1800, 15'h73A0, 3'd0, 1'b0);

        wr(5, 8'h00);  step("scroll_clr2",  15'h1800, 15'h73A0, 3'd0, 1'b1);
        wr(5, 8'hFF);  step("scroll_cy31",  15'h1800, 15'h73E0, 3'd0, 1'b0);
        rstrobe(1'b0, 1'b0, 1'b1, 1'b1);
        step("copy_cy31",    15'h73E0, 15'h73E0, 3'd0, 1'b0);
        rstrobe(1'b0, 1'b1, 1'b0, 1'b0);
        step("inc_vert_cy31", 15'h0000, 15'h73E0, 3'd0, 1'b0);

        rstrobe(1'b1, 1'b0, 1'b0, 1'b0);
        step("inc_hori_plain", 15'h0001, 15'h73E0, 3'd0, 1'b0);
        wr(5, 8'h18);  step("scroll_cx3",   15'h0001, 15'h73E3, 3'd0, 1'b1);
        rd(2);         step("status_clr3",  15'h0001, 15'h73E3, 3'd0, 1'b0);
        rstrobe(1'b1, 1'b0, 1'b1, 1'b0);
        step("copy_beats_inc", 15'h0003, 15'h73E3, 3'd0, 1'b0);

        wr(6, 8'h15);  step("addr_hi_15",   15'h0003, 15'h15E3, 3'd0, 1'b1);
        wr(6, 8'h42);
        rstrobe(1'b0, 1'b1, 1'b0, 1'b0);
        step("addr_beats_incv", 15'h1542, 15'h1542, 3'd0, 1'b0);

        rd(7);         step("data_while_render", v_glitch, 15'h1542, 3'd0, 1'b0);

        wr(5, 8'h0F);  step("scroll_pre_rst", v_glitch, 15'h1541, 3'd7, 1'b1);
        rst = 1'b1;
        wr(5, 8'hAA);
        rstrobe(1'b1, 1'b1, 1'b1, 1'b1);
        step("rst_midpair",  15'h0000, 15'h0000, 3'd0, 1'b0);
        render_en = 1'b0;
        wr(5, 8'h7D);  step("post_rst_scroll", 15'h0000, 15'h000F, 3'd5, 1'b1);

        repeat (3) @(posedge clk);
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
